ps2mouse_packet: RTL

//   Consumes the byte stream from the PS/2 mouse receive path (ps2mouse_ctrl

---
 rtl/ps2mouse_packet.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ps2mouse_packet.sv
// PS/2 mouse packet assembler.
// Takes bytes from the PS/2 receiver and builds 3-byte (or 4-byte IntelliMouse)
// packets. Each committed packet adds its X/Y/Z deltas to free-running 8-bit
// counters, in the same form as the Amiga JOY0DAT counters, and latches the
// button states. If a packet stalls for TIMEOUT_CYC cycles, the partial packet
// is dropped and the assembler resynchronises on the next header byte.
module ps2mouse_packet #(
  parameter int TIMEOUT_CYC = 14000,
  parameter bit CLAMP_OVF   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_stb,
  input  logic       wheel_en,
  output logic [7:0] xcount,
  output logic [7:0] ycount,
  output logic [7:0] zcount,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       pkt_stb,
  output logic       sync_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;

  state_t      r_state;
  logic [TW-1:0] r_timer;
  logic        r_wheel;
  logic [7:0]  r_xcount, r_ycount, r_zcount;
  logic [2:0]  r_btn;
  logic        r_pkt_stb, r_sync_err;

  // Header fields and deltas captured while the packet is being assembled.
  logic [2:0]  r_btn_lat;
  logic        r_sgn_x, r_sgn_y, r_ovf_x, r_ovf_y;
  logic [7:0]  r_dx, r_dy;

  logic        w_commit, w_timeout, w_reject;
  logic [7:0]  w_dy_byte;
  logic [7:0]  w_dx8, w_dy8;
  logic signed [7:0] w_dz;

  // Low byte of the 9-bit delta after overflow handling. A clamped negative
  // value (-256) has low byte 0x00. A clamped positive value (+255) has low
  // byte 0xFF. A dropped axis contributes 0.
  function automatic logic [7:0] sat_delta(input logic sign, input logic ovf,
                                           input logic [7:0] mag);
    if (!ovf)      return mag;
    if (CLAMP_OVF) return sign ? 8'h00 : 8'hFF;
    return 8'h00;
  endfunction

  // Four-bit wheel delta, sign-extended to the counter width.
  function automatic logic signed [7:0] sext_dz(input logic [3:0] nib);
    return $signed({{4{nib[3]}}, nib});
  endfunction

  // In 3-byte mode the packet commits on the dy byte itself, so dy is taken
  // straight from the input rather than from the latch.
  assign w_dy_byte = (r_state == S_B2) ? byte_in : r_dy;
  assign w_dx8     = sat_delta(r_sgn_x, r_ovf_x, r_dx);
  assign w_dy8     = sat_delta(r_sgn_y, r_ovf_y, w_dy_byte);
  assign w_dz      = (r_state == S_B3) ? sext_dz(byte_in[3:0]) : 8'sd0;

  assign w_commit  = byte_stb && (((r_state == S_B2) && !r_wheel) || (r_state == S_B3));
  assign w_reject  = byte_stb && (r_state == S_B0) && !byte_in[3];
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout = !byte_stb && (r_state != S_B0) && (r_timer == TW'(TIMEOUT_CYC - 1));

  // Packet FSM, stall timer, counters, buttons and the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_B0;
      r_timer    <= '0;
      r_wheel    <= 1'b0;
      r_xcount   <= '0;
      r_ycount   <= '0;
      r_zcount   <= '0;
      r_btn      <= '0;
      r_pkt_stb  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_pkt_stb  <= w_commit;
      r_sync_err <= w_reject || w_timeout;

      if (byte_stb || (r_state == S_B0)) r_timer <= '0;
      else                               r_timer <= r_timer + TW'(1);

      if (w_commit) begin
        r_xcount <= r_xcount + w_dx8;
        r_ycount <= r_ycount - w_dy8;
        r_zcount <= r_zcount + $unsigned(w_dz);
        r_btn    <= r_btn_lat;
      end

      if (w_timeout) begin
        r_state <= S_B0;
      end else if (byte_stb) begin
        case (r_state)
          S_B0: if (byte_in[3]) begin
                  r_wheel <= wheel_en;
                  r_state <= S_B1;
                end
          S_B1: r_state <= S_B2;
          S_B2: r_state <= r_wheel ? S_B3 : S_B0;
          default: r_state <= S_B0;
        endcase
      end
    end
  end

  // Byte latches for the packet under construction. They are qualified by the
  // state, so they need no reset.
  always_ff @(posedge clk) begin
    if (byte_stb) begin
      case (r_state)
        S_B0: begin
          r_btn_lat <= byte_in[2:0];
          r_sgn_x   <= byte_in[4];
          r_sgn_y   <= byte_in[5];
          r_ovf_x   <= byte_in[6];
          r_ovf_y   <= byte_in[7];
        end
        S_B1: r_dx <= byte_in;
        S_B2: r_dy <= byte_in;
        default: ;
      endcase
    end
  end

  assign xcount     = r_xcount;
  assign ycount     = r_ycount;
  assign zcount     = r_zcount;
  assign btn_left   = r_btn[0];
  assign btn_right  = r_btn[1];
  assign btn_middle = r_btn[2];
  assign pkt_stb    = r_pkt_stb;
  assign sync_err   = r_sync_err;

endmodule
